// File: rtl/pixel_framer.sv
// Pixel stream framer: tags each accepted pixel with frame/line markers and X/Y, behind a
// two-entry skid buffer. Define PIXEL_FRAMER_THRESH_EN to binarise pixels against THRESHOLD.
module pixel_framer #(
  parameter int PIX_W     = 8,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int THRESHOLD = 128
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Restart,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [PIX_W-1:0] In_Pixel,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [PIX_W-1:0] Out_Pixel,
  output logic             Out_Frame,
  output logic             Out_Line,
  output logic [XW-1:0]    Out_X,
  output logic [YW-1:0]    Out_Y,
  output logic             Frame_Done
);

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic             frame;
    logic             line;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
  } beat_t;

  localparam logic [XW-1:0] LastCol = XW'(IMG_W - 1);
  localparam logic [YW-1:0] LastRow = YW'(IMG_H - 1);

  logic [XW-1:0]    col_q;
  logic [YW-1:0]    row_q;
  logic             ready_q;
  logic             out_vld_q;
  logic             out_vld_d;
  logic             skid_vld_q;
  logic             skid_vld_d;
  beat_t            out_q;
  beat_t            out_d;
  beat_t            skid_q;
  beat_t            skid_d;
  beat_t            new_beat;
  logic [PIX_W-1:0] pix_in;
  logic             accept;
  logic             drain;
  logic             at_last_col;
  logic             at_last_row;
  logic             done_q;

  // Restart masks the registered ready so the pixel offered alongside it is never taken
  assign In_Ready    = ready_q && !Restart;
  assign accept      = In_Valid && In_Ready;
  assign drain       = out_vld_q && Out_Ready && !Restart;
  assign at_last_col = (col_q == LastCol);
  assign at_last_row = (row_q == LastRow);

`ifdef PIXEL_FRAMER_THRESH_EN
  assign pix_in = (In_Pixel >= PIX_W'(THRESHOLD)) ? {PIX_W{1'b1}} : '0;
`else
  assign pix_in = In_Pixel;
`endif

  always_comb begin
    new_beat.pixel = pix_in;
    new_beat.frame = (col_q == '0) && (row_q == '0);
    new_beat.line  = at_last_col;
    new_beat.x     = col_q;
    new_beat.y     = row_q;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (Restart) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        col_q <= '0;
        row_q <= at_last_row ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // The skid entry only fills when the output register is stuck, and always drains first
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (Restart) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || drain) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = new_beat;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = new_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      ready_q    <= !skid_vld_d;
      done_q     <= drain && out_q.line && (out_q.y == LastRow);
    end
  end

  assign Out_Valid  = out_vld_q;
  assign Out_Pixel  = out_q.pixel;
  assign Out_Frame  = out_q.frame;
  assign Out_Line   = out_q.line;
  assign Out_X      = out_q.x;
  assign Out_Y      = out_q.y;
  assign Frame_Done = done_q;

endmodule

// File: tb/tb_pixel_framer.sv
// Self-checking bench for pixel_framer (4x3 image): a queue scoreboard derives tags from the
// running pixel count; build with PIXEL_FRAMER_THRESH_EN to also cover binarisation.
`timescale 1ns/1ps
module tb_pixel_framer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int FRAME = W * H;

  typedef struct packed {
    logic [7:0] pix;
    logic       frame;
    logic       line;
    logic [1:0] x;
    logic [1:0] y;
  } beat_t;

  typedef struct packed {
    logic  rdy;
    logic  vld;
    beat_t beat;
    logic  done;
  } snap_t;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       Restart;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] In_Pixel;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [7:0] Out_Pixel;
  logic       Out_Frame;
  logic       Out_Line;
  logic [1:0] Out_X;
  logic [1:0] Out_Y;
  logic       Frame_Done;

  int    passed = 0;
  int    total = 0;
  beat_t q[$];
  int    n_acc = 0;
  logic  final_pending = 1'b0;
  logic  rdy_arm = 1'b0;
  logic  acc;
  logic  drn;
  snap_t obs_s;
  snap_t exp_s;

  pixel_framer #(
    .PIX_W(8), .IMG_W(W), .IMG_H(H), .XW(2), .YW(2), .THRESHOLD(128)
  ) dut (
    .Clk(Clk), .nReset(nReset), .Restart(Restart),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Pixel(In_Pixel),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Pixel(Out_Pixel),
    .Out_Frame(Out_Frame), .Out_Line(Out_Line), .Out_X(Out_X), .Out_Y(Out_Y),
    .Frame_Done(Frame_Done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] model_pixel(input logic [7:0] p);
`ifdef PIXEL_FRAMER_THRESH_EN
    return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
    return p;
`endif
  endfunction

  // Drives one cycle, samples at the falling edge and advances the scoreboard.
  // Tags come from the count of pixels accepted since the frame began.
  task automatic applyStimulus(input logic iv, input logic [7:0] pix, input logic ordy,
                               input logic rst);
    beat_t b;
    int    k;
    In_Valid  = iv;
    In_Pixel  = pix;
    Out_Ready = ordy;
    Restart   = rst;
    @(negedge Clk);
    if (!nReset) begin
      q.delete();
      n_acc         = 0;
      final_pending = 1'b0;
      rdy_arm       = 1'b0;
    end
    acc        = In_Valid && In_Ready;
    drn        = Out_Valid && Out_Ready && !Restart;
    obs_s.rdy  = In_Ready;
    obs_s.vld  = Out_Valid;
    obs_s.beat = '0;
    if (Out_Valid) obs_s.beat = {Out_Pixel, Out_Frame, Out_Line, Out_X, Out_Y};
    obs_s.done = Frame_Done;
    exp_s.rdy  = rdy_arm && !rst && (q.size() < 2);
    exp_s.vld  = (q.size() != 0);
    exp_s.beat = '0;
    if (q.size() != 0) exp_s.beat = q[0];
    exp_s.done    = final_pending;
    final_pending = 1'b0;
    if (rst) begin
      q.delete();
      n_acc = 0;
    end else if (nReset) begin
      if (drn && q.size() != 0) begin
        b = q.pop_front();
        final_pending = b.line && (b.y == 2'(H - 1));
      end
      if (acc) begin
        k       = n_acc % FRAME;
        b.pix   = model_pixel(In_Pixel);
        b.x     = 2'(k % W);
        b.y     = 2'(k / W);
        b.frame = (k == 0);
        b.line  = ((k % W) == W - 1);
        q.push_back(b);
        n_acc++;
      end
    end
    @(posedge Clk);
    if (nReset) rdy_arm = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    total++;
    if ({In_Ready, Out_Valid, Out_Pixel, Out_Frame, Out_Line, Out_X, Out_Y, Frame_Done} !== '0) begin
      $display("[TB] FAIL reset_values got %h expected 0",
               {In_Ready, Out_Valid, Out_Pixel, Out_Frame, Out_Line, Out_X, Out_Y, Frame_Done});
    end else passed++;
    @(posedge Clk);
    #1;
    nReset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (obs_s !== exp_s) $display("[TB] FAIL reset_cycle got %h expected %h", obs_s, exp_s);
    else passed++;
    total++;
    if (obs_s.rdy !== 1'b0) $display("[TB] FAIL reset_ready_low got %b expected 0", obs_s.rdy);
    else passed++;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (obs_s !== exp_s) $display("[TB] FAIL reset_cycle got %h expected %h", obs_s, exp_s);
    else passed++;
    total++;
    if (obs_s.rdy !== 1'b1) $display("[TB] FAIL reset_ready_up got %b expected 1", obs_s.rdy);
    else passed++;
  endtask

  task automatic test_basic_frame();
    int sent = 0;
    int guard = 0;
    int dones = 0;
    while (sent < FRAME && guard < 100) begin
      applyStimulus(1'b1, 8'(sent), 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL basic_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (obs_s.done) dones++;
      if (acc) sent++;
      guard++;
    end
    total++;
    if (sent != FRAME) $display("[TB] FAIL basic_accepts got %0d expected %0d", sent, FRAME);
    else passed++;
    repeat (3) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL basic_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (obs_s.done) dones++;
    end
    total++;
    if (dones != 1) $display("[TB] FAIL basic_frame_done got %0d expected 1", dones);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int         sent = 0;
    int         guard = 0;
    int         dones = 0;
    logic [7:0] cur = 8'($urandom);
    while (sent < 2 * FRAME && guard < 200) begin
      applyStimulus(1'b1, cur, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL b2b_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (obs_s.done) dones++;
      if (acc) begin
        sent++;
        cur = 8'($urandom);
      end
      guard++;
    end
    total++;
    if (guard != 2 * FRAME) $display("[TB] FAIL b2b_no_bubble got %0d cycles expected %0d", guard, 2 * FRAME);
    else passed++;
    repeat (3) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL b2b_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (obs_s.done) dones++;
    end
    total++;
    if (dones != 2) $display("[TB] FAIL b2b_frame_done got %0d expected 2", dones);
    else passed++;
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         guard = 0;
    logic [7:0] cur = 8'($urandom);
    while (sent < 2 && guard < 20) begin
      applyStimulus(1'b1, cur, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL bp_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (acc) begin
        sent++;
        cur = 8'($urandom);
      end
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, cur, 1'b0, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL bp_hold_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (acc) cur = 8'($urandom);
      if (i >= 1) begin
        total++;
        if (obs_s.rdy !== 1'b0) $display("[TB] FAIL bp_ready_low got %b expected 0", obs_s.rdy);
        else passed++;
      end
    end
    total++;
    if (q.size() != 2) $display("[TB] FAIL bp_held_count got %0d expected 2", q.size());
    else passed++;
    sent  = 0;
    guard = 0;
    while (sent < 6 && guard < 40) begin
      applyStimulus(1'b1, cur, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL bp_release_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (acc) begin
        sent++;
        cur = 8'($urandom);
      end
      guard++;
    end
    repeat (3) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL bp_release_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
    end
  endtask

  task automatic test_restart();
    int         sent = 0;
    int         guard = 0;
    logic [7:0] cur = 8'($urandom);
    beat_t      want;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    while (sent < 7 && guard < 40) begin
      applyStimulus(1'b1, cur, (sent < 6), 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL restart_fill got %h expected %h", obs_s, exp_s);
      else passed++;
      if (acc) begin
        sent++;
        cur = 8'($urandom);
      end
      guard++;
    end
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    total++;
    if (obs_s.rdy !== 1'b0 || acc !== 1'b0)
      $display("[TB] FAIL restart_ready got rdy=%b acc=%b expected 0/0", obs_s.rdy, acc);
    else passed++;
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    total++;
    if (obs_s !== exp_s) $display("[TB] FAIL restart_cycle got %h expected %h", obs_s, exp_s);
    else passed++;
    total++;
    if (obs_s.vld !== 1'b0) $display("[TB] FAIL restart_flush got %b expected 0", obs_s.vld);
    else passed++;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    want = {model_pixel(8'hAA), 1'b1, 1'b0, 2'd0, 2'd0};
    total++;
    if (obs_s.vld !== 1'b1 || obs_s.beat !== want)
      $display("[TB] FAIL restart_tag got %b/%h expected 1/%h", obs_s.vld, obs_s.beat, want);
    else passed++;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (obs_s !== exp_s) $display("[TB] FAIL restart_cycle got %h expected %h", obs_s, exp_s);
    else passed++;
  endtask

  task automatic test_async_reset();
    int         sent = 0;
    int         guard = 0;
    logic       seen = 1'b0;
    logic [7:0] cur = 8'($urandom);
    beat_t      want;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    while (sent < 6 && guard < 30) begin
      applyStimulus(1'b1, cur, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL areset_fill got %h expected %h", obs_s, exp_s);
      else passed++;
      if (acc) begin
        sent++;
        cur = 8'($urandom);
      end
      guard++;
    end
    In_Valid = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    total++;
    if ({In_Ready, Out_Valid, Out_Pixel, Out_Frame, Out_Line, Out_X, Out_Y, Frame_Done} !== '0) begin
      $display("[TB] FAIL areset_immediate got %h expected 0",
               {In_Ready, Out_Valid, Out_Pixel, Out_Frame, Out_Line, Out_X, Out_Y, Frame_Done});
    end else passed++;
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    nReset = 1'b1;
    guard  = 0;
    while (!seen && guard < 10) begin
      applyStimulus(1'b1, cur, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL areset_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (acc) cur = 8'($urandom);
      if (obs_s.vld) begin
        seen = 1'b1;
        want = {obs_s.beat.pix, 1'b1, 1'b0, 2'd0, 2'd0};
        total++;
        if (obs_s.beat !== want) $display("[TB] FAIL areset_first_tag got %h expected %h", obs_s.beat, want);
        else passed++;
      end
      guard++;
    end
    total++;
    if (!seen) $display("[TB] FAIL areset_timeout got no output expected one");
    else passed++;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

`ifdef PIXEL_FRAMER_THRESH_EN
  task automatic test_threshold();
    logic [7:0] tin[4]  = '{8'd127, 8'd128, 8'd255, 8'd0};
    logic [7:0] tout[4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    int         sent = 0;
    int         nd = 0;
    int         guard = 0;
    logic [7:0] cur;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    while ((sent < FRAME || nd < FRAME) && guard < 60) begin
      cur = (sent < 4) ? tin[sent] : 8'($urandom);
      applyStimulus(sent < FRAME, cur, 1'b1, 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL thresh_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
      if (drn) begin
        if (nd < 4) begin
          total++;
          if (obs_s.beat.pix !== tout[nd])
            $display("[TB] FAIL thresh_pixel got %h expected %h", obs_s.beat.pix, tout[nd]);
          else passed++;
        end
        nd++;
      end
      if (acc) sent++;
      guard++;
    end
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_random();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      total++;
      if (obs_s !== exp_s) $display("[TB] FAIL random_cycle got %h expected %h", obs_s, exp_s);
      else passed++;
    end
  endtask

  initial begin
    nReset    = 1'b0;
    Restart   = 1'b0;
    In_Valid  = 1'b0;
    In_Pixel  = 8'h00;
    Out_Ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_backpressure();
    test_restart();
    test_async_reset();
`ifdef PIXEL_FRAMER_THRESH_EN
    test_threshold();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
